// File: rtl/fetch_pkg.sv
// Shared fetch definitions: state encoding, PC step, PC alignment mask.
// Default widths stand in for defines.v when it is not on the include path.
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif
`ifndef Inst_Width
`define Inst_Width 32
`endif

package fetch_pkg;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam int unsigned PC_STEP = 4;

  // Low PC bits cleared on redirect (word alignment).
  localparam logic [1:0] ALIGN_LSB = 2'b11;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: instructions written, full-queue stall cycles.
// Ports: clk, rst (sync, active-low), fetch_evt, stall_evt, perf_* outputs.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_full_stall
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched    <= '0;
      perf_full_stall <= '0;
    end else begin
      if (fetch_evt)
        perf_fetched <= perf_fetched + 32'd1;
      if (stall_evt)
        perf_full_stall <= perf_full_stall + 32'd1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns PC, one outstanding icache request, fills queue.
// Ports: clk, rst, redirect_*, icache_*, q_* , fetch_pc; FETCH_PERF_CNT_EN adds perf_*.
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif
`ifndef Inst_Width
`define Inst_Width 32
`endif

module inst_fetch_unit #(
  parameter int unsigned ADDR_W   = `Inst_Addr_Width,
  parameter int unsigned INST_W   = `Inst_Width,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_ready,
  input  logic              icache_resp_valid,
  input  logic [INST_W-1:0] icache_resp_inst,
  input  logic              q_full,
  output logic              q_write,
  output logic [INST_W-1:0] q_inst,
  output logic [ADDR_W-1:0] q_pc,
  output logic              q_flush,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_full_stall,
`endif
  output logic [ADDR_W-1:0] fetch_pc
);

  import fetch_pkg::*;

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~ADDR_W'(ALIGN_LSB);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;

  logic in_run;
  logic in_wait;
  logic accept;

  assign in_run  = (state == RUN);
  assign in_wait = (state == WAIT);

  // Outputs are gated by rst so the reset cycle presents a quiet interface.
  assign icache_req  = rst && in_run && !q_full && !redirect_valid;
  assign icache_addr = pc;
  assign fetch_pc    = pc;
  assign accept      = icache_req && icache_ready;

  assign q_write = rst && in_wait && icache_resp_valid && !redirect_valid;
  assign q_inst  = q_write ? icache_resp_inst : '0;
  assign q_pc    = q_write ? req_pc : '0;
  assign q_flush = rst && redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      state  <= RUN;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ALIGN_MASK;
      unique case (state)
        WAIT:    state <= icache_resp_valid ? RUN : DROP;
        DROP:    state <= DROP;
        default: state <= RUN;
      endcase
    end else begin
      unique case (state)
        RUN: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + STEP;
            state  <= WAIT;
          end
        end
        WAIT, DROP: begin
          if (icache_resp_valid)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // A response with nothing outstanding is a cache protocol error.
  resp_in_run: assert property (
    @(posedge clk) disable iff (!rst)
    !(in_run && icache_resp_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic stall_evt;

  assign stall_evt = in_run && q_full && !redirect_valid;

  fetch_perf_counters u_perf (
    .clk             (clk),
    .rst             (rst),
    .fetch_evt       (q_write),
    .stall_evt       (stall_evt),
    .perf_fetched    (perf_fetched),
    .perf_full_stall (perf_full_stall)
  );
`endif

endmodule
